bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin bus arbiter that decides which of `SIZE` bus masters owns the shared data bus and drives the select input `S` of the downstream `switch`/`mux_array` bus-decode stage. It accepts per-master requests and issues a registered one-hot grant plus the matching binary select. It enforces a maximum hold time so that no master can starve the others.

## Interface
Parameters:
- `SIZE`, 4: number of requesters; power of two, at least 2; equals `SIZE` of the downstream switch.
- `SEL_WIDTH`, `$clog2(SIZE)`: select width; matches the switch `S` port.
- `MAX_HOLD`, 8: maximum consecutive cycles one grant is held while other requests are pending; at least 1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, `SIZE`: request vector; bit i high means master i wants the bus.
- `gnt`, output, `SIZE`: registered one-hot grant; all-zero when the bus is idle.
- `sel`, output, `SEL_WIDTH`: registered binary index of the granted master; feeds switch `S`.
- `busy`, output, 1: high while any grant is active (equals `|gnt`).

## Operation
- States: `IDLE` (no grant) and `GRANTED` (exactly one `gnt` bit high).
- Round-robin pointer `last` holds the index of the most recently granted master.
- Search order starts at `last+1` modulo `SIZE`, wrapping, and ends at `last`.
- Hold counter `hold_cnt` has width `$clog2(MAX_HOLD+1)` and counts cycles of the current grant.
- In `IDLE`, if `req` is nonzero:
  - grant the first set bit in search order;
  - set `last`, load `sel`, clear `hold_cnt`, go to `GRANTED`.
- In `GRANTED`, with owner `o`, at each edge, first match wins:
  - If `req[o]` is low and other requests are pending: hand off directly to the next requester after `o`. There is no idle cycle.
  - If `req[o]` is low and nothing else is pending: go to `IDLE` and clear `gnt`.
  - If `req[o]` is high, `hold_cnt == MAX_HOLD-1`, and another bit of `req` is set: hand off to the next requester after `o`.
  - If `req[o]` is high, `hold_cnt == MAX_HOLD-1`, and no other request is pending: keep `o` and clear `hold_cnt` (timeout without contention).
  - Otherwise keep `o` and increment `hold_cnt`.
- On every handoff, `hold_cnt` clears to 0 and `last` updates to the new owner.
- `sel` holds its last value while in `IDLE`. This prevents a select change on the tri-state switch when nobody drives the bus.
- `req` bits for the current owner that rise and fall within one cycle have no effect beyond the rules above.
- `gnt` is never multi-hot, in any cycle.

## Timing
- Reset values, applied asynchronously: `gnt`=0, `sel`=0, `busy`=0, state `IDLE`, `hold_cnt`=0.
- `last` resets to `SIZE-1`, so master 0 has top priority after reset.
- Grant latency: `req` sampled high at edge n gives `gnt`/`sel` valid after edge n, i.e. 1 cycle.
- Release latency: owner drops `req` before edge n; `gnt` changes at edge n.
- Maximum hold: under contention, a master holds the bus at most `MAX_HOLD` consecutive cycles.
- Worst-case wait for a requester: `(SIZE-1)*MAX_HOLD` cycles after its request is first sampled.
- `gnt` and `sel` change only on the same edge, so the downstream switch sees a consistent select.
- Reset asserted mid-grant: outputs go to their reset values immediately, without waiting for a clock edge.
- After reset deasserts, the first grant is issued on the first edge that sees `req` nonzero.

## Structure
- Shared defines header holds the state encodings `ARB_IDLE`/`ARB_GRANTED`, alongside the existing `` `DATA_WIDTH `` define.
- Combinational sub-module `rr_pick` takes (`req`, `last`, `exclude_last`) and returns (`found`, `idx`). It is a rotate-then-priority-encode and is instantiated once.
- `gnt` is decoded from the registered `idx` in the same register stage as `sel`.

## Test plan
All scenarios use `SIZE`=4 and `MAX_HOLD`=4.
- **Reset:** assert `reset` mid-cycle during a grant to master 2 → `gnt`=0000, `sel`=0, `busy`=0 immediately. With `req`=1111 after release → first grant is `gnt`=0001, `sel`=0.
- **Single requester:** `req`=0100 held for 10 cycles → `gnt`=0100, `sel`=2 from 1 cycle after request and never drops (timeout reloads, no contention). Drop `req` → `gnt`=0000 next edge, `sel` stays 2.
- **Rotation:** `req`=1111 constant → grant order is 0,1,2,3,0 with each owner held exactly 4 cycles. There is no idle cycle between owners.
- **Early release handoff:** master 1 owns the bus, `req`=1010; master 1 drops `req` after 2 cycles → `gnt`=1000, `sel`=3 on the next edge. The skipped master 2 is not granted.
- **Wrap-around:** `last`=3 and `req`=1001 → master 0 granted, not master 3.
- **One-hot invariant:** random `req` for 10k cycles → `gnt` is always zero or one-hot, `sel` equals the `gnt` index whenever `busy`=1, and no requester waits more than 12 cycles.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus arbiter slice.
package bus_arbiter_pkg;

    // Arbiter FSM encodings: no owner vs. exactly one owner.
    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    // Width of the shared data bus steered by the downstream switch.
    localparam int DATA_WIDTH = 32;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: walks the request vector starting one past `last`
// and returns the first set bit. With exclude_last set, `last` itself is
// never chosen, so a current owner can only hand off to someone else.
module rr_pick #(
    parameter int SIZE      = 4,
    parameter int SEL_WIDTH = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]      req,
    input  logic [SEL_WIDTH-1:0] last,
    input  logic                 exclude_last,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    logic [SEL_WIDTH-1:0] cand_s;

    // Rotated priority search; index arithmetic wraps because SIZE is a power of two.
    always_comb begin
        found  = 1'b0;
        idx    = {SEL_WIDTH{1'b0}};
        cand_s = {SEL_WIDTH{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            cand_s = last + SEL_WIDTH'(i + 1);
            if (!found && req[cand_s] && !(exclude_last && (i == SIZE - 1))) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule : rr_pick

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded hold time. Drives a registered
// one-hot grant and the matching binary select for the bus switch.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int SEL_WIDTH = $clog2(SIZE),
    parameter int MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SIZE-1:0]      req,
    output logic [SIZE-1:0]      gnt,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 busy
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    arb_state_t           state_r, state_s;
    logic [SEL_WIDTH-1:0] last_r, last_s;
    logic [HOLD_W-1:0]    hold_cnt_r, hold_cnt_s;
    logic [SEL_WIDTH-1:0] sel_r, sel_s;
    logic [SIZE-1:0]      gnt_r, gnt_s;
    logic                 busy_r;
    logic                 active_s;
    logic                 exclude_s;
    logic                 owner_req_s;
    logic                 pick_found_s;
    logic [SEL_WIDTH-1:0] pick_idx_s;

    // While granted, `last` is the owner, so searching past it excluding it
    // yields "next requester after the owner"; when idle it is a plain search.
    assign exclude_s   = (state_r == ARB_GRANTED);
    assign owner_req_s = req[last_r];

    rr_pick #(
        .SIZE      (SIZE),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_pick (
        .req          (req),
        .last         (last_r),
        .exclude_last (exclude_s),
        .found        (pick_found_s),
        .idx          (pick_idx_s)
    );

    // Next-state, pointer and hold-counter logic.
    always_comb begin
        state_s    = state_r;
        last_s     = last_r;
        hold_cnt_s = hold_cnt_r;
        active_s   = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    state_s    = ARB_GRANTED;
                    last_s     = pick_idx_s;
                    hold_cnt_s = {HOLD_W{1'b0}};
                    active_s   = 1'b1;
                end else begin
                    hold_cnt_s = {HOLD_W{1'b0}};
                end
            end
            ARB_GRANTED: begin
                active_s = 1'b1;
                if (!owner_req_s || (hold_cnt_r == HOLD_LAST)) begin
                    if (pick_found_s) begin
                        // Handoff: release or timeout with someone waiting.
                        last_s     = pick_idx_s;
                        hold_cnt_s = {HOLD_W{1'b0}};
                    end else if (!owner_req_s) begin
                        state_s    = ARB_IDLE;
                        hold_cnt_s = {HOLD_W{1'b0}};
                        active_s   = 1'b0;
                    end else begin
                        // Timeout with no contention: owner keeps the bus.
                        hold_cnt_s = {HOLD_W{1'b0}};
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            default: begin
                state_s    = ARB_IDLE;
                hold_cnt_s = {HOLD_W{1'b0}};
                active_s   = 1'b0;
            end
        endcase
    end

    // Output decode: select follows the owner and freezes while idle so the
    // switch does not toggle with nobody on the bus.
    always_comb begin
        gnt_s = {SIZE{1'b0}};
        if (active_s) begin
            sel_s         = last_s;
            gnt_s[last_s] = 1'b1;
        end else begin
            sel_s = sel_r;
        end
    end

    // State and output registers; gnt and sel update on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ARB_IDLE;
            last_r     <= SEL_WIDTH'(SIZE - 1);
            hold_cnt_r <= {HOLD_W{1'b0}};
            sel_r      <= {SEL_WIDTH{1'b0}};
            gnt_r      <= {SIZE{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            last_r     <= last_s;
            hold_cnt_r <= hold_cnt_s;
            sel_r      <= sel_s;
            gnt_r      <= gnt_s;
            busy_r     <= active_s;
        end
    end

    assign gnt  = gnt_r;
    assign sel  = sel_r;
    assign busy = busy_r;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter with SIZE=4, MAX_HOLD=4.
module tb_bus_arbiter;

    localparam int SIZE     = 4;
    localparam int SEL_W    = 2;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             reset;
    logic [SIZE-1:0]  req;
    logic [SIZE-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;

    int n_cmp;
    int n_err;
    int wait_cnt [SIZE];

    bus_arbiter #(
        .SIZE      (SIZE),
        .SEL_WIDTH (SEL_W),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic eb);
        check_val({tag, "_gnt"},  32'(gnt),  32'(eg));
        check_val({tag, "_sel"},  32'(sel),  32'(es));
        check_val({tag, "_busy"}, 32'(busy), 32'(eb));
    endtask

    initial begin
        logic [3:0] exp_g;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        req   = 4'b0000;
        #2;
        check_out("reset_init", 4'b0000, 2'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_out("idle_after_reset", 4'b0000, 2'd0, 1'b0);

        // Single requester: never loses the bus, timeout just reloads.
        req = 4'b0100;
        tick();
        check_out("single_first", 4'b0100, 2'd2, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out("single_hold", 4'b0100, 2'd2, 1'b1);
        end
        req = 4'b0000;
        tick();
        check_out("single_release", 4'b0000, 2'd2, 1'b0);

        // Async reset in the middle of a grant to master 2.
        req = 4'b0100;
        tick();
        check_out("pre_reset_grant", 4'b0100, 2'd2, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 4'b0000, 2'd0, 1'b0);
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        check_out("post_reset_grant", 4'b0001, 2'd0, 1'b1);

        // Rotation under full contention: 4 cycles per owner, no idle gap.
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_g = 4'b0001 << ((k / MAX_HOLD) % SIZE);
            check_out("rotation", exp_g, 2'((k / MAX_HOLD) % SIZE), 1'b1);
        end

        // Early release hands off directly, skipping non-requesting master 2.
        req = 4'b0000;
        tick();
        check_out("idle_gap", 4'b0000, 2'd0, 1'b0);
        req = 4'b1010;
        tick();
        check_out("early_owner", 4'b0010, 2'd1, 1'b1);
        tick();
        check_out("early_owner_hold", 4'b0010, 2'd1, 1'b1);
        req = 4'b1000;
        tick();
        check_out("early_handoff", 4'b1000, 2'd3, 1'b1);

        // Wrap-around: last=3, req=1001 picks master 0.
        req = 4'b0000;
        tick();
        check_out("wrap_idle", 4'b0000, 2'd3, 1'b0);
        req = 4'b1001;
        tick();
        check_out("wrap_grant", 4'b0001, 2'd0, 1'b1);

        // Random sticky requests: invariants and bounded wait.
        for (int i = 0; i < SIZE; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] sampled;
            logic [3:0] nreq;
            sampled = req;
            tick();
            check_val("onehot", 32'((gnt & (gnt - 4'd1)) == 4'd0), 32'd1);
            check_val("busy_eq", 32'(busy), 32'(|gnt));
            if (busy) begin
                check_val("sel_match", 32'(gnt), 32'(4'b0001 << sel));
            end else begin
                check_val("idle_gnt", 32'(gnt), 32'd0);
            end
            for (int i = 0; i < SIZE; i++) begin
                if (sampled[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > (SIZE - 1) * MAX_HOLD) begin
                    check_val("wait_bound", 32'(wait_cnt[i]), 32'((SIZE - 1) * MAX_HOLD));
                    wait_cnt[i] = 0;
                end
            end
            nreq = req;
            for (int i = 0; i < SIZE; i++) begin
                if ($urandom_range(7) == 0) nreq[i] = ~nreq[i];
            end
            req = nreq;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bus_arbiter
